decode_stage: RTL and testbench

Instruction-decode stage of the 5-stage pipelined RISC core, sitting directly downstream of the IF/ID register and upstream of EX. It holds the 32-entry register file and decodes the IF/ID instruction into control bits, operands and an immediate. It also detects load-use hazards (stalling PC and IF/ID) and registers everything into the ID/EX pipeline register, inserting bubbles on stall or branch flush.

---
 rtl/riscv_pkg.sv | 55 +++++
 rtl/decode_stage_reg_file.sv | 40 ++++
 rtl/decode_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU op encoding and the control bundle
// carried from ID through EX/MEM.
package riscv_pkg;

  localparam int N = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'('0);

  // funct7[5] only distinguishes SUB for R-type; shifts use it in both formats.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic f7b5,
                                         input logic is_r);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32-entry register file: x0 hardwired to zero, two read ports with
// same-cycle write-through bypass, one write port, async clear.
module reg_file
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   rs1_addr,
  input  logic [4:0]   rs2_addr,
  output logic [N-1:0] rs1_data,
  output logic [N-1:0] rs2_data,
  input  logic         we,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data
);

  logic [31:0][N-1:0] regs_q;
  logic [31:0][N-1:0] regs_d;
  logic               wr_en;

  assign wr_en = we && (wr_addr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0) rs1_data = (wr_en && wr_addr == rs1_addr) ? wr_data : regs_q[rs1_addr];
    if (rs2_addr != 5'd0) rs2_data = (wr_en && wr_addr == rs2_addr) ? wr_data : regs_q[rs2_addr];
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, immediate generation, load-use hazard detection and the
// ID/EX pipeline register (bubbles on stall or flush).
module decode_stage
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] instruction_in,
  input  logic [N-1:0] pc_in,
  input  logic         flush,
  input  logic         wb_we,
  input  logic [4:0]   wb_rd,
  input  logic [N-1:0] wb_data,
  output logic         IFIDwrite,
  output logic         pc_write,
  output logic [N-1:0] idex_pc,
  output logic [N-1:0] idex_rs1_data,
  output logic [N-1:0] idex_rs2_data,
  output logic [N-1:0] idex_imm,
  output logic [4:0]   idex_rs1,
  output logic [4:0]   idex_rs2,
  output logic [4:0]   idex_rd,
  output logic [3:0]   idex_alu_op,
  output logic         idex_alu_src,
  output logic         idex_mem_read,
  output logic         idex_mem_write,
  output logic         idex_reg_write,
  output logic         idex_mem_to_reg,
  output logic         idex_branch
);

  logic [6:0]   opcode;
  logic [4:0]   rs1, rs2, rd;
  logic [N-1:0] rs1_data, rs2_data;
  logic [N-1:0] imm;
  ctrl_t        ctrl;
  logic         uses_rs1, uses_rs2;
  logic         hz, stall;

  ctrl_t        ctrl_d, ctrl_q;
  logic [N-1:0] pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  logic [4:0]   rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;

  assign opcode = instruction_in[6:0];
  assign rs1    = instruction_in[19:15];
  assign rs2    = instruction_in[24:20];
  assign rd     = instruction_in[11:7];

  reg_file u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (wb_we),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  always_comb begin
    ctrl     = CTRL_NOP;
    imm      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.alu_op    = alu_decode(instruction_in[14:12], instruction_in[30], 1'b1);
        ctrl.reg_write = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_I: begin
        ctrl.alu_op    = alu_decode(instruction_in[14:12], instruction_in[30], 1'b0);
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        uses_rs1       = 1'b1;
        imm            = {{(N-12){instruction_in[31]}}, instruction_in[31:20]};
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        uses_rs1        = 1'b1;
        imm             = {{(N-12){instruction_in[31]}}, instruction_in[31:20]};
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        imm            = {{(N-12){instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]};
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        imm         = {{(N-13){instruction_in[31]}}, instruction_in[31], instruction_in[7],
                       instruction_in[30:25], instruction_in[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // Only a load still sitting in ID/EX can create a hazard; a bubble has mem_read=0.
  assign hz = ctrl_q.mem_read && (rd_q != 5'd0) &&
              ((uses_rs1 && rd_q == rs1) || (uses_rs2 && rd_q == rs2));
  assign stall     = hz && !flush;
  assign IFIDwrite = !stall;
  assign pc_write  = !stall;

  always_comb begin
    ctrl_d     = (flush || hz) ? CTRL_NOP : ctrl;
    pc_d       = pc_in;
    rs1_data_d = rs1_data;
    rs2_data_d = rs2_data;
    imm_d      = imm;
    rs1_d      = rs1;
    rs2_d      = rs2;
    rd_d       = rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= CTRL_NOP;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
    end
  end

  assign idex_pc         = pc_q;
  assign idex_rs1_data   = rs1_data_q;
  assign idex_rs2_data   = rs2_data_q;
  assign idex_imm        = imm_q;
  assign idex_rs1        = rs1_q;
  assign idex_rs2        = rs2_q;
  assign idex_rd         = rd_q;
  assign idex_alu_op     = ctrl_q.alu_op;
  assign idex_alu_src    = ctrl_q.alu_src;
  assign idex_mem_read   = ctrl_q.mem_read;
  assign idex_mem_write  = ctrl_q.mem_write;
  assign idex_reg_write  = ctrl_q.reg_write;
  assign idex_mem_to_reg = ctrl_q.mem_to_reg;
  assign idex_branch     = ctrl_q.branch;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a vector table driven one instruction per cycle,
// expected ID/EX contents queued on drive and compared after the clock edge.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction_in, pc_in, wb_data;
  logic        flush, wb_we;
  logic [4:0]  wb_rd;
  logic        IFIDwrite, pc_write;
  logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [3:0]  idex_alu_op;
  logic        idex_alu_src, idex_mem_read, idex_mem_write, idex_reg_write, idex_mem_to_reg, idex_branch;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instruction_in(instruction_in), .pc_in(pc_in), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .IFIDwrite(IFIDwrite), .pc_write(pc_write),
    .idex_pc(idex_pc), .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data),
    .idex_imm(idex_imm), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_alu_op(idex_alu_op), .idex_alu_src(idex_alu_src), .idex_mem_read(idex_mem_read),
    .idex_mem_write(idex_mem_write), .idex_reg_write(idex_reg_write),
    .idex_mem_to_reg(idex_mem_to_reg), .idex_branch(idex_branch)
  );

  // ALU codes and control sets {alu_src,mem_read,mem_write,reg_write,mem_to_reg,branch}
  localparam logic [3:0] A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4,
                         A_SLL = 5, A_SRL = 6, A_SRA = 7, A_SLT = 8, A_SLTU = 9;
  localparam logic [5:0] C_NONE = 6'b000000, C_R = 6'b000100, C_I = 6'b100100,
                         C_LW = 6'b110110, C_SW = 6'b101000, C_BEQ = 6'b000001;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        fl, we;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic        go;
    logic [3:0]  alu;
    logic [5:0]  ctl;
    logic        chkd;
    logic [31:0] r1, r2, imm;
    logic [4:0]  rd;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] pc_cnt = 32'h100;

  function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_enc(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_enc(input logic [11:0] im, input logic [4:0] rs2, rs1);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_enc(input logic [12:0] im, input logic [4:0] rs2, rs1);
    return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic vec_t mk(input string nm, input logic [31:0] instr, input logic fl, we,
                              input logic [4:0] wrd, input logic [31:0] wd, input logic go,
                              input logic [3:0] alu, input logic [5:0] ctl, input logic chkd,
                              input logic [31:0] r1, r2, imm, input logic [4:0] rd);
    vec_t v;
    v.name = nm; v.instr = instr; v.fl = fl; v.we = we; v.wrd = wrd; v.wdata = wd; v.go = go;
    v.alu = alu; v.ctl = ctl; v.chkd = chkd; v.r1 = r1; v.r2 = r2; v.imm = imm; v.rd = rd;
    v.pc = '0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_idex(input vec_t v);
    chk({v.name, " alu_op"}, 32'(idex_alu_op), 32'(v.alu));
    chk({v.name, " ctrl"}, 32'({idex_alu_src, idex_mem_read, idex_mem_write, idex_reg_write,
                               idex_mem_to_reg, idex_branch}), 32'(v.ctl));
    if (v.chkd) begin
      chk({v.name, " rs1_data"}, idex_rs1_data, v.r1);
      chk({v.name, " rs2_data"}, idex_rs2_data, v.r2);
      chk({v.name, " imm"}, idex_imm, v.imm);
      chk({v.name, " rd"}, 32'(idex_rd), 32'(v.rd));
      chk({v.name, " rs1"}, 32'(idex_rs1), 32'(v.instr[19:15]));
      chk({v.name, " rs2"}, 32'(idex_rs2), 32'(v.instr[24:20]));
      chk({v.name, " pc"}, idex_pc, v.pc);
    end
  endtask

  task automatic step(input vec_t v_in);
    vec_t v;
    v = v_in;
    @(negedge clk);
    instruction_in = v.instr; flush = v.fl; wb_we = v.we; wb_rd = v.wrd; wb_data = v.wdata;
    pc_in = pc_cnt;
    v.pc = pc_cnt;
    #1;
    chk({v.name, " IFIDwrite"}, 32'(IFIDwrite), 32'(v.go));
    chk({v.name, " pc_write"}, 32'(pc_write), 32'(v.go));
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected one entry", v.name);
    end else check_idex(sb.pop_front());
    wb_we = 1'b0;
    pc_cnt += 32'd4;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, " IFIDwrite"}, 32'(IFIDwrite), 32'd1);
    chk({nm, " pc_write"}, 32'(pc_write), 32'd1);
    chk({nm, " idex_data"}, idex_pc | idex_rs1_data | idex_rs2_data | idex_imm, 32'd0);
    chk({nm, " idex_idx"}, 32'({idex_rs1, idex_rs2, idex_rd, idex_alu_op}), 32'd0);
    chk({nm, " idex_ctrl"}, 32'({idex_alu_src, idex_mem_read, idex_mem_write, idex_reg_write,
                                idex_mem_to_reg, idex_branch}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] add7, lw6;
    add7 = r_enc(7'h00, 5'd2, 5'd6, 3'b000, 5'd7);
    lw6  = i_enc(12'd0, 5'd1, 3'b010, 5'd6, 7'b0000011);

    rst_n = 1'b0; instruction_in = '0; pc_in = '0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i < 32; i++)
      step(mk($sformatf("rd_x%0d", i), r_enc(7'h00, 5'(i), 5'(i), 3'b000, 5'd3), 0, 0, 0, 0,
              1, A_ADD, C_R, 1, 0, 0, 0, 5'd3));

    vecs.push_back(mk("wr_x1", 32'h0, 0, 1, 5'd1, 32'd5, 1, A_ADD, C_NONE, 0, 0, 0, 0, 0));
    vecs.push_back(mk("wr_x2", 32'h0, 0, 1, 5'd2, 32'd7, 1, A_ADD, C_NONE, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sub", 32'h402081B3, 0, 0, 0, 0, 1, A_SUB, C_R, 1, 5, 7, 0, 5'd3));
    vecs.push_back(mk("addi_byp", 32'hFFF20293, 0, 1, 5'd4, 32'hDEADBEEF, 1, A_ADD, C_I, 1,
                      32'hDEADBEEF, 0, 32'hFFFFFFFF, 5'd5));
    vecs.push_back(mk("wr_x0_byp", r_enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd9), 0, 1, 5'd0, 32'h1234,
                      1, A_ADD, C_R, 1, 0, 0, 0, 5'd9));
    vecs.push_back(mk("rd_x0", r_enc(7'h00, 5'd4, 5'd0, 3'b000, 5'd8), 0, 0, 0, 0,
                      1, A_ADD, C_R, 1, 0, 32'hDEADBEEF, 0, 5'd8));
    vecs.push_back(mk("xor", r_enc(7'h00, 5'd2, 5'd1, 3'b100, 5'd10), 0, 0, 0, 0, 1, A_XOR, C_R, 1, 5, 7, 0, 5'd10));
    vecs.push_back(mk("or", r_enc(7'h00, 5'd2, 5'd1, 3'b110, 5'd10), 0, 0, 0, 0, 1, A_OR, C_R, 1, 5, 7, 0, 5'd10));
    vecs.push_back(mk("and", r_enc(7'h00, 5'd2, 5'd1, 3'b111, 5'd10), 0, 0, 0, 0, 1, A_AND, C_R, 1, 5, 7, 0, 5'd10));
    vecs.push_back(mk("sll", r_enc(7'h00, 5'd2, 5'd1, 3'b001, 5'd10), 0, 0, 0, 0, 1, A_SLL, C_R, 1, 5, 7, 0, 5'd10));
    vecs.push_back(mk("srl", r_enc(7'h00, 5'd2, 5'd1, 3'b101, 5'd10), 0, 0, 0, 0, 1, A_SRL, C_R, 1, 5, 7, 0, 5'd10));
    vecs.push_back(mk("sra", r_enc(7'h20, 5'd2, 5'd1, 3'b101, 5'd10), 0, 0, 0, 0, 1, A_SRA, C_R, 1, 5, 7, 0, 5'd10));
    vecs.push_back(mk("slt", r_enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd10), 0, 0, 0, 0, 1, A_SLT, C_R, 1, 5, 7, 0, 5'd10));
    vecs.push_back(mk("sltu", r_enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd10), 0, 0, 0, 0, 1, A_SLTU, C_R, 1, 5, 7, 0, 5'd10));
    vecs.push_back(mk("xori", i_enc(12'hFFD, 5'd1, 3'b100, 5'd10, 7'b0010011), 0, 0, 0, 0,
                      1, A_XOR, C_I, 1, 5, 0, 32'hFFFFFFFD, 5'd10));
    vecs.push_back(mk("srai", i_enc(12'h403, 5'd1, 3'b101, 5'd12, 7'b0010011), 0, 0, 0, 0,
                      1, A_SRA, C_I, 1, 5, 0, 32'h403, 5'd12));
    vecs.push_back(mk("slli", i_enc(12'h002, 5'd1, 3'b001, 5'd12, 7'b0010011), 0, 0, 0, 0,
                      1, A_SLL, C_I, 1, 5, 7, 32'h2, 5'd12));
    vecs.push_back(mk("beq_fwd", b_enc(13'd8, 5'd2, 5'd1), 0, 0, 0, 0, 1, A_SUB, C_BEQ, 1, 5, 7, 32'd8, 5'd8));
    vecs.push_back(mk("beq_back", b_enc(13'h1FFC, 5'd2, 5'd1), 0, 0, 0, 0,
                      1, A_SUB, C_BEQ, 1, 5, 7, 32'hFFFFFFFC, 5'd29));
    vecs.push_back(mk("sub_flush", 32'h402081B3, 1, 0, 0, 0, 1, A_ADD, C_NONE, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lw_a", lw6, 0, 0, 0, 0, 1, A_ADD, C_LW, 1, 5, 0, 0, 5'd6));
    vecs.push_back(mk("add_stall", add7, 0, 0, 0, 0, 0, A_ADD, C_NONE, 0, 0, 0, 0, 0));
    vecs.push_back(mk("add_go", add7, 0, 0, 0, 0, 1, A_ADD, C_R, 1, 0, 7, 0, 5'd7));
    vecs.push_back(mk("lw_b", lw6, 0, 0, 0, 0, 1, A_ADD, C_LW, 1, 5, 0, 0, 5'd6));
    vecs.push_back(mk("sw_stall", s_enc(12'd4, 5'd6, 5'd1), 0, 0, 0, 0, 0, A_ADD, C_NONE, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sw_go", s_enc(12'd4, 5'd6, 5'd1), 0, 0, 0, 0, 1, A_ADD, C_SW, 1, 5, 0, 4, 5'd4));
    vecs.push_back(mk("lw_c", lw6, 0, 0, 0, 0, 1, A_ADD, C_LW, 1, 5, 0, 0, 5'd6));
    vecs.push_back(mk("addi_rs2only", i_enc(12'd6, 5'd1, 3'b000, 5'd11, 7'b0010011), 0, 0, 0, 0,
                      1, A_ADD, C_I, 1, 5, 0, 6, 5'd11));
    vecs.push_back(mk("lw_d", lw6, 0, 0, 0, 0, 1, A_ADD, C_LW, 1, 5, 0, 0, 5'd6));
    vecs.push_back(mk("add_flush", add7, 1, 0, 0, 0, 1, A_ADD, C_NONE, 0, 0, 0, 0, 0));
    vecs.push_back(mk("add_postflush", add7, 0, 0, 0, 0, 1, A_ADD, C_R, 1, 0, 7, 0, 5'd7));
    vecs.push_back(mk("lw_e", lw6, 0, 0, 0, 0, 1, A_ADD, C_LW, 1, 5, 0, 0, 5'd6));
    vecs.push_back(mk("illegal_rs6", 32'h0003007F, 0, 0, 0, 0, 1, A_ADD, C_NONE, 0, 0, 0, 0, 0));
    vecs.push_back(mk("illegal", 32'h0000007F, 0, 0, 0, 0, 1, A_ADD, C_NONE, 0, 0, 0, 0, 0));

    foreach (vecs[i]) step(vecs[i]);

    // Reset in the middle of a load-use stall.
    step(mk("lw_f", lw6, 0, 0, 0, 0, 1, A_ADD, C_LW, 1, 5, 0, 0, 5'd6));
    @(negedge clk);
    instruction_in = add7;
    #1;
    chk("midreset pre IFIDwrite", 32'(IFIDwrite), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step(mk("post_reset", r_enc(7'h00, 5'd1, 5'd6, 3'b000, 5'd7), 0, 0, 0, 0,
            1, A_ADD, C_R, 1, 0, 0, 0, 5'd7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
